// File: rtl/femto_reset_gen.sv
// femto_reset_gen: reset sequencer clocked by the PLL output.
// Synchronises and filters pll_locked, holds peripherals and core in reset for
// HOLD_CYCLES cycles, releases peripherals at the halfway point and the core at
// the end, and records the cause of the most recent reset.
// Optional watchdog: define FEMTO_RESET_WDT_EN to build it.
// state_dbg exposes the FSM state (0 = WAIT_LOCK, 1 = HOLD, 2 = RUN).
module femto_reset_gen #(
  parameter int HOLD_CYCLES = 1024,
  parameter int LOCK_FILTER = 16,
  parameter int WDT_CYCLES  = 16777216
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       sw_reset_req,
  input  logic       wdt_kick,
  output logic       periph_rst,
  output logic       resetn,
  output logic       ready,
  output logic [1:0] reset_cause,
  output logic [1:0] state_dbg
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int FW = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_HALF = HW'(HOLD_CYCLES / 2);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);

  localparam logic [1:0] CAUSE_POWER = 2'd0;
  localparam logic [1:0] CAUSE_LOCK  = 2'd1;
  localparam logic [1:0] CAUSE_SW    = 2'd2;
  localparam logic [1:0] CAUSE_WDT   = 2'd3;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic [FW-1:0]   filt_cnt, filt_n;
  logic [1:0]      cause_n;
  logic [1:0]      lock_sync;
  logic            lock_s;
  logic            wdt_expire;
  logic            periph_rst_n, resetn_n, ready_n;

  assign lock_s    = lock_sync[1];
  assign state_dbg = state;

  // Two-flop synchroniser for the asynchronous lock indication.
  always_ff @(posedge clk) begin
    if (reset) lock_sync <= 2'b00;
    else       lock_sync <= {lock_sync[0], pll_locked};
  end

`ifdef FEMTO_RESET_WDT_EN
  localparam int WW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

  logic [WW-1:0] wdt_cnt;

  // Watchdog counts only in RUN; a kick or any other state clears it.
  always_ff @(posedge clk) begin
    if (reset || (state != ST_RUN) || wdt_kick) wdt_cnt <= '0;
    else if (wdt_cnt != WDT_LAST)               wdt_cnt <= wdt_cnt + WW'(1);
  end

  // A kick in the terminal cycle wins over expiry.
  assign wdt_expire = (state == ST_RUN) && (wdt_cnt == WDT_LAST) && !wdt_kick;
`else
  logic unused_wdt;
  assign unused_wdt = wdt_kick;
  assign wdt_expire = 1'b0;
`endif

  // Next-state, counter and cause logic; registered outputs decoded from next state.
  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    filt_n  = filt_cnt;
    cause_n = reset_cause;
    case (state)
      ST_WAIT_LOCK: begin
        hold_n = '0;
        if (!lock_s) begin
          filt_n = '0;
        end else if (filt_cnt == FILT_LAST) begin
          state_n = ST_HOLD;
          filt_n  = '0;
        end else begin
          filt_n = filt_cnt + FW'(1);
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_n = ST_WAIT_LOCK;
          cause_n = CAUSE_LOCK;
          hold_n  = '0;
          filt_n  = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_n = ST_RUN;
          hold_n  = '0;
        end else begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      ST_RUN: begin
        hold_n = '0;
        filt_n = '0;
        if (!lock_s) begin
          state_n = ST_WAIT_LOCK;
          cause_n = CAUSE_LOCK;
        end else if (wdt_expire) begin
          state_n = ST_HOLD;
          cause_n = CAUSE_WDT;
        end else if (sw_reset_req) begin
          state_n = ST_HOLD;
          cause_n = CAUSE_SW;
        end
      end
      default: begin
        state_n = ST_WAIT_LOCK;
        hold_n  = '0;
        filt_n  = '0;
      end
    endcase

    periph_rst_n = 1'b1;
    if (state_n == ST_RUN)       periph_rst_n = 1'b0;
    else if (state_n == ST_HOLD) periph_rst_n = (hold_n < HOLD_HALF);
    resetn_n = (state_n == ST_RUN);
    ready_n  = (state_n == ST_RUN);
  end

  // State, counters, cause and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_WAIT_LOCK;
      hold_cnt    <= '0;
      filt_cnt    <= '0;
      reset_cause <= CAUSE_POWER;
      periph_rst  <= 1'b1;
      resetn      <= 1'b0;
      ready       <= 1'b0;
    end else begin
      state       <= state_n;
      hold_cnt    <= hold_n;
      filt_cnt    <= filt_n;
      reset_cause <= cause_n;
      periph_rst  <= periph_rst_n;
      resetn      <= resetn_n;
      ready       <= ready_n;
    end
  end

endmodule

// File: tb/tb_femto_reset_gen.sv
// Directed testbench for femto_reset_gen (HOLD_CYCLES=16, LOCK_FILTER=4, WDT_CYCLES=64).
// Cycle t of a scenario: inputs set just after posedge t drive cycle t and are
// sampled at the following edge; outputs read at that point show cycle t.
module tb_femto_reset_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic       wdt_kick = 1'b0;
  logic       periph_rst;
  logic       resetn;
  logic       ready;
  logic [1:0] reset_cause;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  femto_reset_gen #(
    .HOLD_CYCLES(16),
    .LOCK_FILTER(4),
    .WDT_CYCLES (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .sw_reset_req(sw_reset_req),
    .wdt_kick    (wdt_kick),
    .periph_rst  (periph_rst),
    .resetn      (resetn),
    .ready       (ready),
    .reset_cause (reset_cause),
    .state_dbg   (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  initial begin
    int not_ready;

    // Power-up: reset for cycles 0..4, lock from cycle 10.
    tick();
    for (int t = 0; t <= 40; t++) begin
      reset      = (t < 5);
      pll_locked = (t >= 10);
      if (t == 3) begin
        chk("rst_state", state_dbg, S_WAIT);
        chk("rst_resetn", resetn, 0);
        chk("rst_periph", periph_rst, 1);
        chk("rst_ready", ready, 0);
        chk("rst_cause", reset_cause, 0);
      end
      if (t == 15) chk("pu_wait15", state_dbg, S_WAIT);
      if (t == 16) begin
        chk("pu_hold16", state_dbg, S_HOLD);
        chk("pu_periph16", periph_rst, 1);
      end
      if (t == 23) chk("pu_periph23", periph_rst, 1);
      if (t == 24) begin
        chk("pu_periph24", periph_rst, 0);
        chk("pu_resetn24", resetn, 0);
      end
      if (t == 31) begin
        chk("pu_resetn31", resetn, 0);
        chk("pu_ready31", ready, 0);
      end
      if (t == 32) begin
        chk("pu_resetn32", resetn, 1);
        chk("pu_ready32", ready, 1);
        chk("pu_run32", state_dbg, S_RUN);
      end
      if (t == 40) chk("pu_cause", reset_cause, 0);
      tick();
    end

    // Lock glitch: high at 10, low at 12, high again from 13.
    for (int t = 0; t <= 40; t++) begin
      reset      = (t < 5);
      pll_locked = (t >= 10) && (t != 12);
      if (t == 18) chk("gl_wait18", state_dbg, S_WAIT);
      if (t == 19) chk("gl_hold19", state_dbg, S_HOLD);
      if (t == 34) chk("gl_resetn34", resetn, 0);
      if (t == 35) chk("gl_resetn35", resetn, 1);
      tick();
    end

    // Lock loss in RUN: pll low for cycles 2..4.
    for (int t = 0; t <= 30; t++) begin
      pll_locked = !(t >= 2 && t <= 4);
      if (t == 4) chk("ll_resetn4", resetn, 1);
      if (t == 5) begin
        chk("ll_resetn5", resetn, 0);
        chk("ll_periph5", periph_rst, 1);
        chk("ll_ready5", ready, 0);
        chk("ll_state5", state_dbg, S_WAIT);
        chk("ll_cause5", reset_cause, 1);
      end
      if (t == 10) chk("ll_wait10", state_dbg, S_WAIT);
      if (t == 11) chk("ll_hold11", state_dbg, S_HOLD);
      if (t == 19) chk("ll_periph19", periph_rst, 0);
      if (t == 26) chk("ll_resetn26", resetn, 0);
      if (t == 27) begin
        chk("ll_resetn27", resetn, 1);
        chk("ll_cause27", reset_cause, 1);
      end
      tick();
    end

    // Software reset pulse at cycle 2.
    for (int t = 0; t <= 25; t++) begin
      sw_reset_req = (t == 2);
      if (t == 2) chk("sw_resetn2", resetn, 1);
      if (t == 3) begin
        chk("sw_resetn3", resetn, 0);
        chk("sw_state3", state_dbg, S_HOLD);
        chk("sw_periph3", periph_rst, 1);
        chk("sw_cause3", reset_cause, 2);
      end
      if (t == 10) chk("sw_periph10", periph_rst, 1);
      if (t == 11) chk("sw_periph11", periph_rst, 0);
      if (t == 18) chk("sw_resetn18", resetn, 0);
      if (t == 19) chk("sw_resetn19", resetn, 1);
      tick();
    end
    sw_reset_req = 1'b0;

    // Watchdog: kick every 50 cycles up to 200, then stop.
    not_ready = 0;
    for (int t = 0; t <= 300; t++) begin
      wdt_kick = (t % 50 == 0) && (t <= 200);
      if (t <= 250 && !ready) not_ready++;
      if (t == 250) chk("wd_kicked_run", not_ready, 0);
      if (t == 264) chk("wd_ready264", ready, 1);
      if (t == 265) begin
`ifdef FEMTO_RESET_WDT_EN
        chk("wd_ready265", ready, 0);
        chk("wd_state265", state_dbg, S_HOLD);
        chk("wd_cause265", reset_cause, 3);
`else
        chk("wd_ready265", ready, 1);
        chk("wd_state265", state_dbg, S_RUN);
        chk("wd_cause265", reset_cause, 2);
`endif
      end
`ifdef FEMTO_RESET_WDT_EN
      if (t == 281) chk("wd_run281", state_dbg, S_RUN);
`else
      if (t == 300) chk("wd_run300", ready, 1);
`endif
      tick();
    end
    wdt_kick = 1'b0;

    // sw_reset_req coincident with lock_s drop, then reset mid-HOLD.
    for (int t = 0; t <= 40; t++) begin
      pll_locked   = !(t >= 2 && t <= 4);
      sw_reset_req = (t == 4);
      reset        = (t == 15);
      if (t == 4) chk("sim_run4", state_dbg, S_RUN);
      if (t == 5) begin
        chk("sim_state5", state_dbg, S_WAIT);
        chk("sim_cause5", reset_cause, 1);
      end
      if (t == 11) chk("sim_hold11", state_dbg, S_HOLD);
      if (t == 15) chk("sim_hold15", state_dbg, S_HOLD);
      if (t == 16) begin
        chk("mr_state16", state_dbg, S_WAIT);
        chk("mr_cause16", reset_cause, 0);
        chk("mr_periph16", periph_rst, 1);
        chk("mr_resetn16", resetn, 0);
      end
      if (t == 21) chk("mr_wait21", state_dbg, S_WAIT);
      if (t == 22) chk("mr_hold22", state_dbg, S_HOLD);
      if (t == 29) chk("mr_periph29", periph_rst, 1);
      if (t == 30) chk("mr_periph30", periph_rst, 0);
      if (t == 37) chk("mr_resetn37", resetn, 0);
      if (t == 38) begin
        chk("mr_resetn38", resetn, 1);
        chk("mr_cause38", reset_cause, 0);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
